// File: rtl/ex_div_unit_pkg.sv
// Shared definitions for the EX-stage divider: datapath width, div_sel bit
// positions and op codes, FSM state encoding and a word-result helper.
// Optional feature macro used elsewhere in this slice: DIV_EARLY_OUT_EN.
package ex_div_unit_pkg;

    localparam int DIV_XLEN  = 64;
    localparam int DIV_CNT_W = 7;

    // div_sel bit positions
    localparam int SEL_UNS_BIT  = 0;
    localparam int SEL_REM_BIT  = 1;
    localparam int SEL_WORD_BIT = 2;

    // div_sel op codes (bit 2 set selects the W form)
    localparam logic [2:0] DIV_OP_DIV  = 3'b000;
    localparam logic [2:0] DIV_OP_DIVU = 3'b001;
    localparam logic [2:0] DIV_OP_REM  = 3'b010;
    localparam logic [2:0] DIV_OP_REMU = 3'b011;
    localparam logic [2:0] DIV_OP_WORD = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // W-form results are the low word sign-extended from bit 31
    function automatic logic [DIV_XLEN-1:0] word_sext(input logic [DIV_XLEN-1:0] v);
        return {{(DIV_XLEN-32){v[31]}}, v[31:0]};
    endfunction

endpackage

// File: rtl/div_special_chk.sv
// Operand preparation for the divider: W-form extension, operand signs,
// magnitudes, and the divide-by-zero / signed-overflow flags.
// With DIV_EARLY_OUT_EN defined it also flags |dividend| < |divisor|.
module div_special_chk
    import ex_div_unit_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic [2:0]      div_sel_i,
    output logic [XLEN-1:0] a_ext_o,
    output logic [XLEN-1:0] abs_a_o,
    output logic [XLEN-1:0] abs_b_o,
    output logic            neg_a_o,
    output logic            neg_b_o,
    output logic            zero_o,
    output logic            ovf_o,
    output logic            early_o
);

    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

    logic            uns;
    logic            word;
    logic [XLEN-1:0] b_ext;

    // Extend W operands, derive signs and magnitudes, detect special cases
    always_comb begin
        uns  = div_sel_i[SEL_UNS_BIT];
        word = div_sel_i[SEL_WORD_BIT];
        if (word) begin
            a_ext_o = uns ? {{(XLEN-32){1'b0}}, src1_i[31:0]} : {{(XLEN-32){src1_i[31]}}, src1_i[31:0]};
            b_ext   = uns ? {{(XLEN-32){1'b0}}, src2_i[31:0]} : {{(XLEN-32){src2_i[31]}}, src2_i[31:0]};
        end else begin
            a_ext_o = src1_i;
            b_ext   = src2_i;
        end
        neg_a_o = ~uns & a_ext_o[XLEN-1];
        neg_b_o = ~uns & b_ext[XLEN-1];
        abs_a_o = neg_a_o ? -a_ext_o : a_ext_o;
        abs_b_o = neg_b_o ? -b_ext : b_ext;
        zero_o  = (b_ext == '0);
        ovf_o   = ~uns & (b_ext == '1) & (a_ext_o == (word ? MIN_W : MIN_X));
`ifdef DIV_EARLY_OUT_EN
        early_o = ~zero_o & (abs_a_o < abs_b_o);
`else
        early_o = 1'b0;
`endif
    end

endmodule

// File: rtl/ex_div_unit.sv
// EX-stage iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and
// their W forms. Holds the pipeline via stall_req_o until the result is
// valid, then presents it in DONE until hold_i releases.
// Handshake: the op is accepted in IDLE when div_en_i=1 and flush_i=0;
// div_valid_o is high only in DONE; the pipeline advances on a cycle with
// div_valid_o=1 and hold_i=0, which is also the last DONE cycle.
// Optional feature macro: DIV_EARLY_OUT_EN (skip iteration when
// |dividend| < |divisor|).
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_en_i,
    input  logic [2:0]      div_sel_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    input  logic            hold_i,
    output logic            stall_req_o,
    output logic            div_valid_o,
    output logic [XLEN-1:0] div_result_o
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dvsr_q, dvsr_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             rem_op_q, rem_op_d;
    logic             word_q, word_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;

    logic [XLEN-1:0]  a_ext, abs_a, abs_b;
    logic             neg_a, neg_b, zero_div, ovf, early;

    logic [XLEN:0]    rem_shift, trial;
    logic [XLEN-1:0]  rem_step, quo_step, q_fix, r_fix, calc_sel, calc_res;
    logic [XLEN-1:0]  spec_q, spec_r, spec_sel, spec_res;

    div_special_chk #(.XLEN(XLEN)) u_chk (
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .div_sel_i (div_sel_i),
        .a_ext_o   (a_ext),
        .abs_a_o   (abs_a),
        .abs_b_o   (abs_b),
        .neg_a_o   (neg_a),
        .neg_b_o   (neg_b),
        .zero_o    (zero_div),
        .ovf_o     (ovf),
        .early_o   (early)
    );

    // One restoring step plus the sign-fixed result of the final step
    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        trial     = rem_shift - {1'b0, dvsr_q};
        rem_step  = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
        quo_step  = {quo_q[XLEN-2:0], ~trial[XLEN]};
        q_fix     = q_neg_q ? -quo_step : quo_step;
        r_fix     = r_neg_q ? -rem_step : rem_step;
        calc_sel  = rem_op_q ? r_fix : q_fix;
        calc_res  = word_q ? word_sext(calc_sel) : calc_sel;
    end

    // Fixed results for zero divisor, signed overflow and early-out
    always_comb begin
        if (zero_div) begin
            spec_q = '1;
            spec_r = a_ext;
        end else if (ovf) begin
            spec_q = a_ext;
            spec_r = '0;
        end else begin
            spec_q = '0;
            spec_r = a_ext;
        end
        spec_sel = div_sel_i[SEL_REM_BIT] ? spec_r : spec_q;
        spec_res = div_sel_i[SEL_WORD_BIT] ? word_sext(spec_sel) : spec_sel;
    end

    // Next-state and datapath update; flush wins over every transition
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvsr_d   = dvsr_q;
        result_d = result_q;
        rem_op_d = rem_op_q;
        word_d   = word_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        unique case (state_q)
            IDLE: begin
                if (div_en_i) begin
                    rem_op_d = div_sel_i[SEL_REM_BIT];
                    word_d   = div_sel_i[SEL_WORD_BIT];
                    q_neg_d  = neg_a ^ neg_b;
                    r_neg_d  = neg_a;
                    // W dividends sit in the top half so bit shifting starts at bit 31
                    quo_d    = div_sel_i[SEL_WORD_BIT] ? {abs_a[XLEN-33:0], 32'b0} : abs_a;
                    rem_d    = '0;
                    dvsr_d   = abs_b;
                    cnt_d    = div_sel_i[SEL_WORD_BIT] ? CNT_W'(32) : CNT_W'(XLEN);
                    if (zero_div || ovf || early) begin
                        result_d = spec_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                quo_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = calc_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (!hold_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
            rem_op_q <= 1'b0;
            word_q   <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvsr_q   <= dvsr_d;
            result_q <= result_d;
            rem_op_q <= rem_op_d;
            word_q   <= word_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
        end
    end

    assign div_valid_o  = (state_q == DONE);
    assign stall_req_o  = div_en_i & ~div_valid_o;
    assign div_result_o = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: hand-computed vectors for every op form,
// special cases, flush, hold in DONE and asynchronous reset mid-iteration.
// Honours DIV_EARLY_OUT_EN for the latency of small-dividend vectors.
module tb_ex_div_unit;
    import ex_div_unit_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 65;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_en_i = 1'b0;
    logic [2:0]  div_sel_i = 3'b000;
    logic [63:0] src1_i = '0;
    logic [63:0] src2_i = '0;
    logic        flush_i = 1'b0;
    logic        hold_i = 1'b0;
    logic        stall_req_o;
    logic        div_valid_o;
    logic [63:0] div_result_o;

    int checks = 0;
    int failures = 0;
    int proto_err = 0;
    logic op_busy = 1'b0;

    ex_div_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .div_en_i     (div_en_i),
        .div_sel_i    (div_sel_i),
        .src1_i       (src1_i),
        .src2_i       (src2_i),
        .flush_i      (flush_i),
        .hold_i       (hold_i),
        .stall_req_o  (stall_req_o),
        .div_valid_o  (div_valid_o),
        .div_result_o (div_result_o)
    );

    // clock
    always #5 clk = ~clk;

    // div_en_i must stay high while an op is in flight unless it is flushed
    always @(negedge clk) begin
        if (rst_n && op_busy && !div_en_i && !flush_i) proto_err++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%016h exp=0x%016h", tag, act, exp);
        end
    endtask

    // Issue one op, measure latency from the accept cycle, check the result,
    // optionally hold DONE for hold_cycles extra cycles, then retire it.
    task automatic run_op(input string tag, input logic [2:0] sel, input logic [63:0] a,
                          input logic [63:0] b, input int exp_lat, input logic [63:0] exp_res,
                          input int hold_cycles);
        int lat;
        int stall_bad;
        @(negedge clk);
        div_sel_i = sel;
        src1_i    = a;
        src2_i    = b;
        div_en_i  = 1'b1;
        hold_i    = (hold_cycles > 0);
        op_busy   = 1'b1;
        #1;
        check({tag, "_stall_T"}, 64'(stall_req_o), 64'd1);
        lat = 0;
        stall_bad = 0;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (div_valid_o) break;
            if (stall_req_o !== 1'b1) stall_bad++;
        end
        op_busy = 1'b0;
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, div_result_o, exp_res);
        check({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
        check({tag, "_stall_done"}, 64'(stall_req_o), 64'd0);
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 64'(div_valid_o), 64'd1);
            check({tag, "_hold_res"}, div_result_o, exp_res);
        end
        hold_i   = 1'b0;
        div_en_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_retire"}, 64'(div_valid_o), 64'd0);
    endtask

    initial begin
        int saw;

        // reset
        #12;
        check("reset_valid", 64'(div_valid_o), 64'd0);
        check("reset_result", div_result_o, 64'd0);
        check("reset_stall", 64'(stall_req_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // main function, 64-bit and W forms
        run_op("div_m7_2",   DIV_OP_DIV,  -64'sd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("rem_m7_2",   DIV_OP_REM,  -64'sd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("remu_100_7", DIV_OP_REMU, 64'd100, 64'd7, 65, 64'd2, 0);
        run_op("divu_100_7", DIV_OP_DIVU, 64'd100, 64'd7, 65, 64'd14, 0);
        run_op("div_7_m2",   DIV_OP_DIV,  64'd7, -64'sd2, 65, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("rem_7_m2",   DIV_OP_REM,  64'd7, -64'sd2, 65, 64'd1, 0);
        run_op("divu_big",   DIV_OP_DIVU, 64'h7FFF_FFFF_FFFF_FFFF, 64'h10, 65, 64'h07FF_FFFF_FFFF_FFFF, 0);
        run_op("remu_big",   DIV_OP_REMU, 64'h7FFF_FFFF_FFFF_FFFF, 64'h10, 65, 64'hF, 0);
        run_op("divuw",      DIV_OP_WORD | DIV_OP_DIVU, 64'hFFFF_FFFF_8000_0000, 64'd2, 33, 64'h0000_0000_4000_0000, 0);
        run_op("divw_m20_3", DIV_OP_WORD | DIV_OP_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 33, 64'hFFFF_FFFF_FFFF_FFFA, 0);
        run_op("remw_m20_3", DIV_OP_WORD | DIV_OP_REM, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 33, 64'hFFFF_FFFF_FFFF_FFFE, 0);

        // special cases
        run_op("div_by0",    DIV_OP_DIV, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("rem_by0",    DIV_OP_REM, 64'd5, 64'd0, 1, 64'd5, 0);
        run_op("div_ovf",    DIV_OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000, 0);
        run_op("remw_ovf",   DIV_OP_WORD | DIV_OP_REM, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0, 0);

        // small dividend: early-out when enabled, full iteration otherwise
        run_op("divu_3_10",  DIV_OP_DIVU, 64'd3, 64'd10, EO_LAT, 64'd0, 0);
        run_op("remu_3_10",  DIV_OP_REMU, 64'd3, 64'd10, EO_LAT, 64'd3, 0);

        // hold for three DONE cycles: result visible for four cycles
        run_op("hold_divw",  DIV_OP_WORD | DIV_OP_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 33, 64'hFFFF_FFFF_FFFF_FFFA, 3);

        // flush mid-iteration kills the op
        @(negedge clk);
        div_sel_i = DIV_OP_DIV;
        src1_i    = -64'sd7;
        src2_i    = 64'd2;
        div_en_i  = 1'b1;
        op_busy   = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        flush_i  = 1'b1;
        div_en_i = 1'b0;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        op_busy = 1'b0;
        check("flush_valid", 64'(div_valid_o), 64'd0);
        saw = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (div_valid_o) saw++;
        end
        check("flush_no_valid", 64'(saw), 64'd0);
        run_op("after_flush", DIV_OP_DIV, -64'sd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD, 0);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        div_sel_i = DIV_OP_DIVU;
        src1_i    = 64'h7FFF_FFFF_FFFF_FFFF;
        src2_i    = 64'h10;
        div_en_i  = 1'b1;
        op_busy   = 1'b1;
        repeat (20) @(posedge clk);
        #3;
        rst_n    = 1'b0;
        div_en_i = 1'b0;
        op_busy  = 1'b0;
        #1;
        check("arst_valid", 64'(div_valid_o), 64'd0);
        check("arst_result", div_result_o, 64'd0);
        check("arst_stall", 64'(stall_req_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (div_valid_o) saw++;
        end
        check("arst_no_valid", 64'(saw), 64'd0);
        run_op("after_arst", DIV_OP_REMU, 64'd100, 64'd7, 65, 64'd2, 0);

        check("protocol", 64'(proto_err), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
